// File: rtl/dbus_pkg.sv
// Shared dBus definitions: register word offsets, CTRL bit indices, command payload
// struct and a byte-lane merge helper used by dBus responders.
package dbus_pkg;

  localparam int unsigned DBUS_ADDR_W = 32;
  localparam int unsigned DBUS_DATA_W = 32;
  localparam int unsigned DBUS_MASK_W = 4;

  // Timer register map, expressed as word indices (byte offset / 4)
  localparam int unsigned REG_MTIME_LO = 0;
  localparam int unsigned REG_MTIME_HI = 1;
  localparam int unsigned REG_CMP_LO   = 2;
  localparam int unsigned REG_CMP_HI   = 3;
  localparam int unsigned REG_CTRL     = 4;
  localparam int unsigned REG_PRESCALE = 5;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_W      = 2;

  typedef struct packed {
    logic [DBUS_ADDR_W-1:0] addr;
    logic [DBUS_DATA_W-1:0] data;
    logic [DBUS_MASK_W-1:0] size;
    logic                   wr;
  } dbus_cmd_t;

  // Replace only the byte lanes whose mask bit is set
  function automatic logic [DBUS_DATA_W-1:0] merge_bytes(
    input logic [DBUS_DATA_W-1:0] old_v,
    input logic [DBUS_DATA_W-1:0] new_v,
    input logic [DBUS_MASK_W-1:0] mask
  );
    logic [DBUS_DATA_W-1:0] res;
    res = old_v;
    for (int unsigned b = 0; b < DBUS_MASK_W; b++) begin
      if (mask[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dbus_timer_if.sv
// dBus command/response bundle between the core (master) and a responder (slave).
interface dbus_timer_if;
  import dbus_pkg::*;

  logic                   dBus_cmd_valid;
  logic                   dBus_cmd_ready;
  logic [DBUS_ADDR_W-1:0] dBus_cmd_payload_addr;
  logic [DBUS_DATA_W-1:0] dBus_cmd_payload_data;
  logic [DBUS_MASK_W-1:0] dBus_cmd_payload_size;
  logic                   dBus_cmd_payload_wr;
  logic                   dBus_rsp_valid;
  logic [DBUS_DATA_W-1:0] dBus_rsp_data;
  logic                   dBus_rsp_error;

  modport master (
    output dBus_cmd_valid, dBus_cmd_payload_addr, dBus_cmd_payload_data,
           dBus_cmd_payload_size, dBus_cmd_payload_wr,
    input  dBus_cmd_ready, dBus_rsp_valid, dBus_rsp_data, dBus_rsp_error
  );

  modport slave (
    input  dBus_cmd_valid, dBus_cmd_payload_addr, dBus_cmd_payload_data,
           dBus_cmd_payload_size, dBus_cmd_payload_wr,
    output dBus_cmd_ready, dBus_rsp_valid, dBus_rsp_data, dBus_rsp_error
  );
endinterface

// File: rtl/timer_prescaler.sv
// Tick divider for dbus_timer; only built when DBUS_TIMER_PRESCALE_EN is defined.
`ifdef DBUS_TIMER_PRESCALE_EN
module timer_prescaler #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstf,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] prescale_i,
  output logic             tick_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One tick every prescale_i+1 enabled cycles
  assign tick_c_o = en_i & (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clear_i || tick_c_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/dbus_timer.sv
// Memory-mapped machine timer on the dBus: 64-bit mtime/mtimecmp, CTRL and level irq.
// Define DBUS_TIMER_PRESCALE_EN to map PRESCALE at 0x14 and divide the tick rate.
module dbus_timer
  import dbus_pkg::*;
#(
  parameter int unsigned BASE_OFFSET_W = 5
) (
  input  logic        clk,
  input  logic        rstf,
  dbus_timer_if.slave dbus,
  output logic        timer_irq
);

  dbus_cmd_t              cmd_c;
  logic [31:0]            word_idx_c;
  logic                   accept_c, rd_c, wr_c, hit_c, tick_c;
  logic [DBUS_DATA_W-1:0] live_word_c, new_word_c;
  logic                   unused_addr_c;

  logic                   cmd_ready_q;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DBUS_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_error_q, rsp_error_d;
  logic                   irq_q, irq_d;
  logic [63:0]            mtime_q, mtime_d;
  logic [63:0]            cmp_q, cmp_d;
  logic [31:0]            shadow_q, shadow_d;
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d;

`ifdef DBUS_TIMER_PRESCALE_EN
  localparam int unsigned PRESCALE_W = 16;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  presc_wr_c;
`endif

  assign cmd_c = '{addr: dbus.dBus_cmd_payload_addr,
                   data: dbus.dBus_cmd_payload_data,
                   size: dbus.dBus_cmd_payload_size,
                   wr:   dbus.dBus_cmd_payload_wr};

  // Bits outside the decoded window are resolved by the top-level decode
  assign unused_addr_c = ^{cmd_c.addr[DBUS_ADDR_W-1:BASE_OFFSET_W], cmd_c.addr[1:0]};
  assign word_idx_c    = 32'(cmd_c.addr[BASE_OFFSET_W-1:2]);

  assign accept_c = dbus.dBus_cmd_valid & cmd_ready_q;
  assign rd_c     = accept_c & ~cmd_c.wr;
  assign wr_c     = accept_c & cmd_c.wr & (cmd_c.size != '0);

  // Live value of the addressed word and whether it is mapped
  always_comb begin
    live_word_c = '0;
    hit_c       = 1'b1;
    case (word_idx_c)
      REG_MTIME_LO: live_word_c = mtime_q[31:0];
      REG_MTIME_HI: live_word_c = mtime_q[63:32];
      REG_CMP_LO:   live_word_c = cmp_q[31:0];
      REG_CMP_HI:   live_word_c = cmp_q[63:32];
      REG_CTRL:     live_word_c = 32'(ctrl_q);
      REG_PRESCALE: begin
`ifdef DBUS_TIMER_PRESCALE_EN
        live_word_c = 32'(prescale_q);
`else
        hit_c = 1'b0;
`endif
      end
      default:      hit_c = 1'b0;
    endcase
  end

  assign new_word_c = merge_bytes(live_word_c, cmd_c.data, cmd_c.size);

`ifdef DBUS_TIMER_PRESCALE_EN
  assign presc_wr_c = wr_c & (word_idx_c == REG_PRESCALE);

  timer_prescaler #(
    .CNT_W(PRESCALE_W)
  ) u_prescaler (
    .clk       (clk),
    .rstf      (rstf),
    .en_i      (ctrl_q[CTRL_EN]),
    .clear_i   (presc_wr_c),
    .prescale_i(prescale_q),
    .tick_c_o  (tick_c)
  );
`else
  assign tick_c = ctrl_q[CTRL_EN];
`endif

  // Next state: a write to either mtime half replaces the tick for that cycle
  always_comb begin
    mtime_d     = tick_c ? (mtime_q + 64'd1) : mtime_q;
    cmp_d       = cmp_q;
    shadow_d    = shadow_q;
    ctrl_d      = ctrl_q;
    rsp_valid_d = rd_c;
    rsp_data_d  = '0;
    rsp_error_d = 1'b0;
    irq_d       = ctrl_q[CTRL_IRQ_EN] & (mtime_q >= cmp_q);
`ifdef DBUS_TIMER_PRESCALE_EN
    prescale_d  = prescale_q;
`endif

    if (rd_c) begin
      rsp_error_d = ~hit_c;
      rsp_data_d  = (word_idx_c == REG_MTIME_HI) ? shadow_q : live_word_c;
      if (word_idx_c == REG_MTIME_LO) shadow_d = mtime_q[63:32];
    end

    if (wr_c) begin
      case (word_idx_c)
        REG_MTIME_LO: mtime_d = {mtime_q[63:32], new_word_c};
        REG_MTIME_HI: mtime_d = {new_word_c, mtime_q[31:0]};
        REG_CMP_LO:   cmp_d[31:0]  = new_word_c;
        REG_CMP_HI:   cmp_d[63:32] = new_word_c;
        REG_CTRL:     ctrl_d = new_word_c[CTRL_W-1:0];
`ifdef DBUS_TIMER_PRESCALE_EN
        REG_PRESCALE: prescale_d = new_word_c[PRESCALE_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      irq_q       <= 1'b0;
      mtime_q     <= '0;
      cmp_q       <= '1;
      shadow_q    <= '0;
      ctrl_q      <= '0;
`ifdef DBUS_TIMER_PRESCALE_EN
      prescale_q  <= '0;
`endif
    end else begin
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      irq_q       <= irq_d;
      mtime_q     <= mtime_d;
      cmp_q       <= cmp_d;
      shadow_q    <= shadow_d;
      ctrl_q      <= ctrl_d;
`ifdef DBUS_TIMER_PRESCALE_EN
      prescale_q  <= prescale_d;
`endif
    end
  end

  assign dbus.dBus_cmd_ready = cmd_ready_q;
  assign dbus.dBus_rsp_valid = rsp_valid_q;
  assign dbus.dBus_rsp_data  = rsp_data_q;
  assign dbus.dBus_rsp_error = rsp_error_q;
  assign timer_irq           = irq_q;

endmodule

// File: tb/tb_dbus_timer.sv
// Self-checking bench for dbus_timer: directed vector table, hand-written timing
// sequences and a randomized run against a transaction-level reference model.
module tb_dbus_timer;

`ifdef DBUS_TIMER_PRESCALE_EN
  localparam bit PRESC_ON = 1'b1;
`else
  localparam bit PRESC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstf = 1'b0;
  logic timer_irq;

  dbus_timer_if bus ();

  dbus_timer #(.BASE_OFFSET_W(5)) dut (
    .clk      (clk),
    .rstf     (rstf),
    .dbus     (bus),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (register contents as seen after the last edge)
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_shadow;
  logic [15:0] m_presc;
  int unsigned m_pcnt;
  bit          m_en, m_irq_en, m_ready;
  bit          e_valid, e_err, e_irq;
  logic [31:0] e_data;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  size;
    bit          exp_valid;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] bytemask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] model_read(input int unsigned idx);
    case (idx)
      0:       return m_mtime[31:0];
      1:       return m_shadow;
      2:       return m_cmp[31:0];
      3:       return m_cmp[63:32];
      4:       return {30'd0, m_irq_en, m_en};
      5:       return {16'd0, m_presc};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtime = 64'd0; m_cmp = '1; m_shadow = 32'd0; m_presc = 16'd0;
    m_pcnt = 0; m_en = 1'b0; m_irq_en = 1'b0; m_ready = 1'b0;
  endtask

  // Advance the model across one clock edge with the given command on the bus
  task automatic model_edge(input bit v, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    int unsigned idx;
    bit acc, mapped, tick;
    logic [31:0] mk, merged;
    idx    = int'(a[4:2]);
    acc    = v && m_ready;
    mapped = (idx <= 4) || (idx == 5 && PRESC_ON);
    mk     = bytemask(s);
    e_irq  = m_irq_en && (m_mtime >= m_cmp);
    tick   = 1'b0;
    if (!m_en) m_pcnt = 0;
    else if (m_pcnt == int'(m_presc)) begin tick = 1'b1; m_pcnt = 0; end
    else m_pcnt++;
    e_valid = acc && !w;
    e_err   = e_valid && !mapped;
    e_data  = (e_valid && mapped) ? model_read(idx) : 32'd0;
    if (e_valid && idx == 0) m_shadow = m_mtime[63:32];
    if (acc && w && s != 4'd0 && mapped) begin
      merged = idx == 1 ? m_mtime[63:32] : model_read(idx);
      merged = (merged & ~mk) | (d & mk);
      case (idx)
        0: begin m_mtime[31:0]  = merged; tick = 1'b0; end
        1: begin m_mtime[63:32] = merged; tick = 1'b0; end
        2: m_cmp[31:0]  = merged;
        3: m_cmp[63:32] = merged;
        4: begin m_en = merged[0]; m_irq_en = merged[1]; end
        default: begin m_presc = merged[15:0]; m_pcnt = 0; end
      endcase
    end
    if (tick) m_mtime = m_mtime + 64'd1;
    m_ready = 1'b1;
  endtask

  // One bus cycle: drive, clock, update model, sample 1ns after the edge
  task automatic step(input bit v, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    bus.dBus_cmd_valid        = v;
    bus.dBus_cmd_payload_wr   = w;
    bus.dBus_cmd_payload_addr = a;
    bus.dBus_cmd_payload_data = d;
    bus.dBus_cmd_payload_size = s;
    @(posedge clk);
    model_edge(v, w, a, d, s);
    #1;
    chk1("model_rsp_valid", bus.dBus_rsp_valid, e_valid);
    if (e_valid) begin
      chk32("model_rsp_data", bus.dBus_rsp_data, e_data);
      chk1("model_rsp_error", bus.dBus_rsp_error, e_err);
    end
    chk1("model_irq", timer_irq, e_irq);
    chk1("model_ready", bus.dBus_cmd_ready, m_ready);
    bus.dBus_cmd_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'd0, 4'hF);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    step(1'b1, 1'b1, a, d, s);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  task automatic do_reset();
    bus.dBus_cmd_valid = 1'b0;
    rstf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_ready", bus.dBus_cmd_ready, 1'b0);
    chk1("reset_rsp_valid", bus.dBus_rsp_valid, 1'b0);
    chk32("reset_rsp_data", bus.dBus_rsp_data, 32'd0);
    chk1("reset_rsp_error", bus.dBus_rsp_error, 1'b0);
    chk1("reset_irq", timer_irq, 1'b0);
    rstf = 1'b1;
    idle();
    chk1("ready_after_reset", bus.dBus_cmd_ready, 1'b1);
  endtask

  initial begin
    bus.dBus_cmd_valid        = 1'b0;
    bus.dBus_cmd_payload_wr   = 1'b0;
    bus.dBus_cmd_payload_addr = 32'd0;
    bus.dBus_cmd_payload_data = 32'd0;
    bus.dBus_cmd_payload_size = 4'd0;

    tbl.push_back('{1'b0, 32'h0C, 32'h0, 4'hF, 1'b1, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b0, 32'h08, 32'h0, 4'hF, 1'b1, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b0, 32'h00, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h04, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h18, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'h1C, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 32'h14, 32'h0, 4'hF, 1'b1, 32'h0, !PRESC_ON});
    tbl.push_back('{1'b1, 32'h08, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h08, 32'h0, 4'hF, 1'b1, 32'h1234_5678, 1'b0});
    tbl.push_back('{1'b1, 32'h08, 32'hDEAD_BEEF, 4'h0, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h08, 32'h0, 4'hF, 1'b1, 32'h1234_5678, 1'b0});
    tbl.push_back('{1'b1, 32'h18, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 32'h1C, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h08, 32'h0, 4'hF, 1'b1, 32'h1234_5678, 1'b0});
    tbl.push_back('{1'b0, 32'h0C, 32'h0, 4'hF, 1'b1, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b1, 32'h0C, 32'h00AB_0000, 4'b0100, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0C, 32'h0, 4'hF, 1'b1, 32'hFFAB_FFFF, 1'b0});
    tbl.push_back('{1'b1, 32'h10, 32'hFFFF_FFFC, 4'hF, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 32'h10, 32'h0000_0002, 4'h1, 1'b0, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'h2, 1'b0});
    tbl.push_back('{1'b0, 32'hF000_0008, 32'h0, 4'hF, 1'b1, 32'h1234_5678, 1'b0});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].size);
      chk1($sformatf("vec%0d_valid", i), bus.dBus_rsp_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        chk32($sformatf("vec%0d_data", i), bus.dBus_rsp_data, tbl[i].exp_data);
        chk1($sformatf("vec%0d_error", i), bus.dBus_rsp_error, tbl[i].exp_err);
      end
    end

    // irq rises once mtime reaches CMP and falls after CMP is raised
    do_reset();
    wr(32'h08, 32'd10, 4'hF);
    wr(32'h0C, 32'd0, 4'hF);
    wr(32'h10, 32'd3, 4'hF);
    for (int k = 1; k <= 11; k++) begin
      idle();
      chk1($sformatf("irq_step%0d", k), timer_irq, k == 11);
    end
    wr(32'h08, 32'd1000, 4'hF);
    chk1("irq_hold_after_cmp_write", timer_irq, 1'b1);
    idle();
    chk1("irq_fall", timer_irq, 1'b0);

    // 64-bit snapshot across the LO carry into HI
    do_reset();
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(32'h04, 32'd5, 4'hF);
    wr(32'h10, 32'd1, 4'hF);
    rd(32'h00); chk32("snap_lo_a", bus.dBus_rsp_data, 32'hFFFF_FFFF);
    rd(32'h04); chk32("snap_hi_a", bus.dBus_rsp_data, 32'd5);
    rd(32'h00); chk32("snap_lo_b", bus.dBus_rsp_data, 32'd1);
    rd(32'h04); chk32("snap_hi_b", bus.dBus_rsp_data, 32'd6);

    // Full 64-bit wrap from all-ones
    do_reset();
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    wr(32'h10, 32'd1, 4'hF);
    rd(32'h00); chk32("wrap_lo_max", bus.dBus_rsp_data, 32'hFFFF_FFFF);
    rd(32'h04); chk32("wrap_hi_max", bus.dBus_rsp_data, 32'hFFFF_FFFF);
    rd(32'h00); chk32("wrap_lo_after", bus.dBus_rsp_data, 32'd1);
    rd(32'h04); chk32("wrap_hi_after", bus.dBus_rsp_data, 32'd0);

    // Byte write over a tick: only lane 1 replaced, tick dropped that cycle
    do_reset();
    wr(32'h00, 32'h1122_3344, 4'hF);
    wr(32'h10, 32'd1, 4'hF);
    wr(32'h00, 32'h0000_AB00, 4'b0010);
    rd(32'h00); chk32("bytewr_lo", bus.dBus_rsp_data, 32'h1122_AB44);
    rd(32'h00); chk32("bytewr_lo_next", bus.dBus_rsp_data, 32'h1122_AB45);

    // HI write on a carrying tick keeps the pre-tick LO
    do_reset();
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(32'h10, 32'd1, 4'hF);
    wr(32'h04, 32'd7, 4'hF);
    rd(32'h00); chk32("hiwr_lo", bus.dBus_rsp_data, 32'hFFFF_FFFF);
    rd(32'h04); chk32("hiwr_hi", bus.dBus_rsp_data, 32'd7);

    // Tick rate: PRESCALE=3 divides by 4 when mapped, otherwise the write is dropped
    do_reset();
    wr(32'h14, 32'd3, 4'hF);
    wr(32'h10, 32'd1, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      rd(32'h00);
      chk32($sformatf("rate_step%0d", k), bus.dBus_rsp_data,
            32'((k - 1) / (PRESC_ON ? 4 : 1)));
    end

    // Reset asserted while a response is on the bus
    do_reset();
    wr(32'h08, 32'd5, 4'hF);
    rd(32'h08);
    chk1("midrst_rsp_before", bus.dBus_rsp_valid, 1'b1);
    #2 rstf = 1'b0;
    #1;
    chk1("midrst_rsp_killed", bus.dBus_rsp_valid, 1'b0);
    chk1("midrst_ready_low", bus.dBus_cmd_ready, 1'b0);
    do_reset();
    rd(32'h08); chk32("midrst_cmp_restored", bus.dBus_rsp_data, 32'hFFFF_FFFF);

    // Randomized traffic checked against the model inside step()
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int unsigned word;
      bit v, w;
      logic [31:0] a, d;
      word = $urandom_range(0, 7);
      v    = ($urandom_range(0, 9) < 7);
      w    = $urandom_range(0, 1) == 1;
      a    = ($urandom() & 32'hFFFF_FFE0) | 32'(word << 2) | 32'($urandom_range(0, 3));
      d    = $urandom();
      if (w && $urandom_range(0, 1) == 1) begin
        case (word)
          0, 2: d = 32'($urandom_range(0, 300));
          1, 3: d = 32'd0;
          5:    d = 32'($urandom_range(0, 5));
          default: ;
        endcase
      end
      step(v, w, a, d, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
